// File: rtl/dm_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// controller states and the default decoded address width.
package dm_access_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int MEM_ADDR_BITS_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/dm_access_ctrl_lane.sv
// Combinational lane logic: pulls a byte/halfword lane out of a memory word with
// sign or zero extension, and merges store data into a word for read-modify-write.
module dm_lane_unit
    import dm_access_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] base_word,
    input  logic [31:0] wdata,
    output logic [31:0] ext_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b   = rd_word[{offset, 3'b000} +: 8];
        lane_h   = rd_word[{offset[1], 4'b0000} +: 16];
        ext_data = rd_word;
        merged   = base_word;
        case (size)
            SZ_BYTE: begin
                ext_data = sgn ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                ext_data = sgn ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
                merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ext_data = rd_word;
                merged   = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data memory controller: one request at a time, sub-word stores done
// as aligned read-modify-write, response held until the consumer takes it.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DEF,
    parameter int DATA_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [31:0]       dm_addr,
    output logic              dm_wren,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the requester holds its request stable until accepted.
    state_t      state_q, state_d;
    logic        we_q, sgn_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q, merge_q;
    logic [31:0] ext_data, merged;
    logic [31:0] addr_aligned;
    logic        req_err;

    assign addr_aligned = {addr_q[31:2], 2'b00};
    assign req_err = (req_size == 2'b11)
                   || (req_size == SZ_HALF && req_addr[0])
                   || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                   || ((req_addr >> MEM_ADDR_BITS) != 32'd0);

    dm_lane_unit u_lane (
        .size      (size_q),
        .sgn       (sgn_q),
        .offset    (addr_q[1:0]),
        .rd_word   (dm_rdata),
        .base_word (merge_q),
        .wdata     (wdata_q),
        .ext_data  (ext_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    sgn_q   <= req_signed;
                    size_q  <= req_size;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    err_q   <= req_err;
                    rdata_q <= '0;
                end
                ST_ACCESS: begin
                    if (!we_q) rdata_q <= ext_data;
                    else       merge_q <= dm_rdata;
                end
                default: ;
            endcase
        end
    end

    // Memory outputs are decoded from state alone so reset kills dm_wren at once.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        dm_wren    = 1'b0;
        dm_wdata   = '0;
        dm_addr    = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_err ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                dm_addr = addr_aligned;
                if (we_q && size_q == SZ_WORD) begin
                    dm_wren  = 1'b1;
                    dm_wdata = wdata_q;
                end
                state_d = (we_q && size_q != SZ_WORD) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                dm_addr  = addr_aligned;
                dm_wren  = 1'b1;
                dm_wdata = merged;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                dm_addr    = addr_aligned;
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: a byte-level memory model predicts load data, write
// words, error flags and latencies for directed and random requests.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_wren;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:255];
    logic [7:0]  ref_mem [0:1023];
    int          wren_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    always #5 clk = ~clk;

    dm_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .dm_addr(dm_addr),
        .dm_wren(dm_wren), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dbg_state(dbg_state)
    );

    assign dm_rdata = mem[dm_addr[9:2]];

    always @(posedge clk) begin
        if (dm_wren) begin
            mem[dm_addr[9:2]] <= dm_wdata;
            wren_cnt     <= wren_cnt + 1;
            last_wr_addr <= dm_addr;
            last_wr_data <= dm_wdata;
        end
    end

    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0)
            || (size == 2'd2 && addr % 4 != 0) || (addr >= 32'd1024);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int b = int'(addr[9:0]) / 4 * 4;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr);
        int     n = 1 << size;
        longint v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(addr[9:0]) + i]) << (8 * i));
        if (sgn && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
        int n = 1 << size;
        for (int i = 0; i < n; i++) ref_mem[int'(addr[9:0]) + i] = 8'(wdata >> (8 * i));
    endtask

    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        logic        exp_err;
        logic [31:0] exp_rdata, exp_word;
        int          exp_lat, exp_wren, cycles, w0;
        exp_err   = ref_err(size, addr);
        exp_rdata = (exp_err || we) ? 32'd0 : ref_load(size, sgn, addr);
        exp_wren  = (!exp_err && we) ? 1 : 0;
        exp_lat   = exp_err ? 1 : ((we && size != 2'd2) ? 3 : 2);
        if (exp_wren == 1) ref_store(size, addr, wdata);
        w0 = wren_cnt;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL %s req_ready idle got=%b want=1", name, req_ready);
        end
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr;
        req_wdata = wdata; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cycles = 1;
        while (resp_valid !== 1'b1 && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
        total++;
        if (cycles != exp_lat) begin
            bad++; $display("FAIL %s latency got=%0d want=%0d", name, cycles, exp_lat);
        end
        total++;
        if (resp_rdata !== exp_rdata || resp_err !== exp_err) begin
            bad++; $display("FAIL %s resp got=%h/%b want=%h/%b", name, resp_rdata, resp_err,
                            exp_rdata, exp_err);
        end
        if (!exp_err) begin
            total++;
            if (dm_addr !== {addr[31:2], 2'b00}) begin
                bad++; $display("FAIL %s dm_addr got=%h want=%h", name, dm_addr,
                                {addr[31:2], 2'b00});
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || req_ready !== 1'b0) begin
                bad++; $display("FAIL %s hold%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                                name, h, resp_valid, resp_rdata, req_ready, exp_rdata);
            end
        end
        resp_ready = 1'b1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++; $display("FAIL %s req_ready at handshake got=%b want=0", name, req_ready);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL %s after handshake got v=%b rdy=%b want v=0 rdy=1", name,
                            resp_valid, req_ready);
        end
        total++;
        if (wren_cnt - w0 != exp_wren) begin
            bad++; $display("FAIL %s write count got=%0d want=%0d", name, wren_cnt - w0, exp_wren);
        end
        if (exp_wren == 1) begin
            exp_word = ref_word(addr);
            total++;
            if (last_wr_addr !== {addr[31:2], 2'b00} || last_wr_data !== exp_word) begin
                bad++; $display("FAIL %s write got=%h@%h want=%h@%h", name, last_wr_data,
                                last_wr_addr, exp_word, {addr[31:2], 2'b00});
            end
        end
        if (addr < 32'd1024) begin
            total++;
            if (mem[addr[9:2]] !== ref_word(addr)) begin
                bad++; $display("FAIL %s memory got=%h want=%h", name, mem[addr[9:2]],
                                ref_word(addr));
            end
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 ||
            resp_err !== 1'b0 || dm_addr !== 32'd0 || dm_wren !== 1'b0 || dm_wdata !== 32'd0) begin
            bad++; $display("FAIL reset outputs got rdy=%b v=%b d=%h e=%b a=%h we=%b wd=%h",
                            req_ready, resp_valid, resp_rdata, resp_err, dm_addr, dm_wren, dm_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dbg_state !== 2'd0) begin
            bad++; $display("FAIL reset release got rdy=%b v=%b st=%0d want rdy=1 v=0 st=0",
                            req_ready, resp_valid, dbg_state);
        end
    endtask

    task automatic test_word_store_load();
        do_req("word_store", 1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 0);
        do_req("word_load", 1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 0);
    endtask

    task automatic test_byte_store();
        do_req("byte_store", 1'b1, 2'd0, 1'b0, 32'h012, 32'h0000005A, 0);
        do_req("byte_load12", 1'b0, 2'd0, 1'b1, 32'h012, 32'h0, 0);
        do_req("byte_load13", 1'b0, 2'd0, 1'b1, 32'h013, 32'h0, 0);
    endtask

    task automatic test_half_store();
        do_req("preload", 1'b1, 2'd2, 1'b0, 32'h020, 32'h11223344, 0);
        do_req("half_store", 1'b1, 2'd1, 1'b0, 32'h020, 32'h00008001, 0);
        do_req("half_load_s", 1'b0, 2'd1, 1'b1, 32'h020, 32'h0, 0);
        do_req("half_load_u", 1'b0, 2'd1, 1'b0, 32'h020, 32'h0, 0);
    endtask

    task automatic test_errors();
        do_req("err_half_mis", 1'b0, 2'd1, 1'b1, 32'h021, 32'h0, 0);
        do_req("err_range", 1'b1, 2'd2, 1'b0, 32'h402, 32'hCAFEF00D, 0);
        do_req("err_size", 1'b1, 2'd3, 1'b0, 32'h014, 32'h12345678, 0);
        do_req("err_word_mis", 1'b1, 2'd2, 1'b0, 32'h016, 32'h12345678, 0);
    endtask

    task automatic test_back_pressure();
        logic [31:0] keep;
        int          w0;
        do_req("bp_load", 1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 5);
        keep = mem[32'h030 >> 2];
        w0 = wren_cnt;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h010; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h030; req_wdata = $urandom; req_valid = 1'b1;
        for (int h = 0; h < 3; h++) begin
            total++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
                bad++; $display("FAIL bp_busy%0d got v=%b rdy=%b want v=1 rdy=0", h,
                                resp_valid, req_ready);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || wren_cnt != w0 || mem[32'h030 >> 2] !== keep) begin
            bad++; $display("FAIL bp_ignored got v=%b writes=%0d mem=%h want v=0 writes=0 mem=%h",
                            resp_valid, wren_cnt - w0, mem[32'h030 >> 2], keep);
        end
    endtask

    task automatic test_reset_during_rmw();
        int w0;
        w0 = wren_cnt;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h011;
        req_wdata = 32'h000000A5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (dm_wren !== 1'b1) begin
            bad++; $display("FAIL rmw_write_cycle dm_wren got=%b want=1", dm_wren);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (dm_wren !== 1'b0) begin
            bad++; $display("FAIL rmw_reset dm_wren got=%b want=0", dm_wren);
        end
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || wren_cnt != w0 ||
            mem[32'h011 >> 2] !== ref_word(32'h011)) begin
            bad++; $display("FAIL rmw_abort got rdy=%b v=%b writes=%0d mem=%h want 1 0 0 %h",
                            req_ready, resp_valid, wren_cnt - w0, mem[32'h011 >> 2],
                            ref_word(32'h011));
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) addr = 32'h400 + $urandom_range(0, 4095);
            else addr = $urandom_range(0, 127);
            do_req("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        test_reset();
        test_word_store_load();
        test_byte_store();
        test_half_store();
        test_errors();
        test_back_pressure();
        test_reset_during_rmw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator-side controller that drives the word-wide data memory port (byte-addressed, little-endian, 1024 bytes, combinational read, synchronous write) on behalf of the MEM pipeline stage.
- Accepts load/store requests over a valid/ready handshake.
- Handles byte, halfword and word accesses.
- Performs sub-word stores as aligned read-modify-write sequences.
- Returns sign- or zero-extended load data with an error flag.

Parameters:
- MEM_ADDR_BITS, 10, byte-address bits decoded by the data memory; any higher set address bit is out of range.
- DATA_W, 32, word width; fixed at 32, present for documentation only.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  sign-extend load result.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal-size request.
- dm_addr  out  32  word-aligned address to the memory: {req_addr[31:2],2'b00}.
- dm_wren  out  1  memory write enable.
- dm_wdata  out  32  memory write data.
- dm_rdata  in  32  memory combinational read data.

Behaviour:
- Reset (async): state IDLE. All outputs are 0 except req_ready=1. dm_wren drops immediately when rst asserts. Reset during RMW aborts the operation; no partial write is issued.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch the request.
  - Error if any of: size=11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:MEM_ADDR_BITS]!=0.
  - On error, go to RESP with err=1 and perform no memory access. Otherwise go to ACCESS.
- ACCESS (dm_addr driven from the latched address):
  - Load: capture dm_rdata at the end of the cycle. Extract the lane by addr[1:0] (byte) or addr[1] (halfword). Extend per req_signed. Go to RESP.
  - Word store: dm_wren=1, dm_wdata=req_wdata. Go to RESP.
  - Sub-word store: dm_wren=0. Capture dm_rdata into the merge register. Go to WRITE.
- WRITE: dm_wren=1. dm_wdata = merge word with the selected byte or halfword lane replaced by req_wdata[7:0] or req_wdata[15:0]. Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On resp_ready, go to IDLE. req_ready rises the following cycle; there is no same-cycle turnaround.
- Latency, request accept to resp_valid: load 2 cycles, word store 2, sub-word store 3, error 1.
- dm_wren is high for exactly one cycle per store. It is never high in IDLE or RESP.
- dm_addr holds the latched aligned address from ACCESS through RESP, and is 0 in IDLE.
- req_valid while not ready is ignored. The requester holds the request stable.
- Store responses: resp_rdata=0.
- Error responses: resp_rdata=0, resp_err=1.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encoding constants;
  - MEM_ADDR_BITS default.
- One natural sub-module, dm_lane_unit: purely combinational. It performs lane extraction with sign/zero extension and lane merge for stores.

Test Plan:
- Word store 0xDEADBEEF at 0x010, then word load at 0x010: dm_wren pulses once with dm_addr=0x010, and the load returns 0xDEADBEEF, err=0, 2 cycles after accept.
- After that store, byte store 0x5A at 0x012: a read cycle, then a write cycle of 0xDE5ABEEF. A signed byte load at 0x012 returns 0x0000005A; a signed byte load at 0x013 returns 0xFFFFFFDE.
- Halfword store 0x8001 at 0x020 over preloaded 0x11223344 writes 0x11228001. A signed halfword load at 0x020 returns 0xFFFF8001; an unsigned one returns 0x00008001.
- Misaligned halfword load at 0x021 and word store at 0x402 (out of range): resp_err=1 one cycle after accept, dm_wren never asserted, memory unchanged.
- Back-pressure: hold resp_ready=0 for 5 cycles. resp_valid and resp_rdata stay stable, req_ready stays 0, and a new req_valid is not accepted until the cycle after the handshake.
- Assert rst during the WRITE cycle of a byte store: dm_wren falls immediately, the target word is unchanged, and after release req_ready=1 and resp_valid=0.
